// File: rtl/layer_output_serializer.sv
// Captures a layer's parallel neuron outputs and streams them one word per cycle,
// lowest neuron first, with a one-deep pending buffer for a vector that arrives mid-stream.
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons-1:0]           x_valid,
    input  logic [numNeurons*dataWidth-1:0] x_in,
    output logic [dataWidth-1:0]            data_out,
    output logic                            data_out_valid,
    output logic                            busy,
    output logic                            overflow,
    output logic                            valid_mismatch
);

    localparam int VW = numNeurons * dataWidth;
    localparam int CW = $clog2(numNeurons + 1);
    localparam logic [CW-1:0] LAST = CW'(numNeurons - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VW-1:0]         active_q, active_d;
    logic [VW-1:0]         pend_q, pend_d;
    logic                  pendFull_q, pendFull_d;
    logic [dataWidth-1:0]  dataOut_q, dataOut_d;
    logic                  outValid_q, outValid_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic                  mismatch_q, mismatch_d;

    logic capture;
    logic lastWord;

    // Next-state logic; outputs are precomputed from the next state so that they
    // come straight out of registers with word 0 visible the cycle after capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pendFull_d = pendFull_q;
        overflow_d = overflow_q;
        mismatch_d = mismatch_q | ((x_valid != '0) && (x_valid != '1));

        capture  = x_valid[0];
        lastWord = (state_q == SHIFT) && (cnt_q == LAST);

        case (state_q)
            IDLE: begin
                if (capture) begin
                    active_d = x_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (lastWord) begin
                    // Pending vector has priority; a same-cycle capture backfills it.
                    if (pendFull_q) begin
                        active_d   = pend_q;
                        cnt_d      = '0;
                        pendFull_d = capture;
                        if (capture) begin
                            pend_d = x_in;
                        end
                    end else if (capture) begin
                        active_d = x_in;
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (capture) begin
                        if (!pendFull_q) begin
                            pend_d     = x_in;
                            pendFull_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        outValid_d = (state_d == SHIFT);
        dataOut_d  = outValid_d ? active_d[int'(cnt_d)*dataWidth +: dataWidth] : '0;
        busy_d     = outValid_d | pendFull_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pendFull_q <= 1'b0;
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
            dataOut_q  <= dataOut_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign data_out       = dataOut_q;
    assign data_out_valid = outValid_q;
    assign busy           = busy_q;
    assign overflow       = overflow_q;
    assign valid_mismatch = mismatch_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed scoreboard bench for layer_output_serializer with four 16-bit neurons:
// expected words are queued when a vector is offered and popped as the DUT streams.
module tb_layer_output_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   x_valid = '0;
    logic [N*W-1:0] x_in = '0;
    logic [W-1:0]   data_out;
    logic           data_out_valid;
    logic           busy;
    logic           overflow;
    logic           valid_mismatch;

    logic [W-1:0] sb[$];
    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    layer_output_serializer #(.numNeurons(N), .dataWidth(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .x_valid        (x_valid),
        .x_in           (x_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .overflow       (overflow),
        .valid_mismatch (valid_mismatch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] makeVec(input logic [W-1:0] base);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(i);
        return v;
    endfunction

    // Drives one capture edge; the words are queued only if the vector should be emitted.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] vec, input bit expectEmit);
        x_valid = v;
        x_in    = vec;
        if (expectEmit) begin
            for (int i = 0; i < N; i++) sb.push_back(vec[i*W +: W]);
        end
        tick();
        x_valid = '0;
    endtask

    task automatic idleCycle();
        x_valid = '0;
        tick();
    endtask

    task automatic expectStream(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            checkOutput(tag, 32'(data_out_valid), 32'd1);
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic expectQuiet(input string tag);
        checkOutput({tag, " valid low"}, 32'(data_out_valid), 32'd0);
        checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
        checkOutput({tag, " queue drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Every output word is checked against the scoreboard head; idle cycles must show zero data.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious word", 32'(data_out_valid), 32'd0);
                end else begin
                    checkOutput("stream word", 32'(data_out), 32'(sb.pop_front()));
                end
            end else begin
                checkOutput("idle data zero", 32'(data_out), 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset data_out", 32'(data_out), 32'd0);
        checkOutput("reset valid", 32'(data_out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset mismatch", 32'(valid_mismatch), 32'd0);
        rst = 1'b0;
        idleCycle();

        // Single vector {4,3,2,1}
        applyStimulus(4'hF, makeVec(16'h0001), 1'b1);
        expectStream("single valid", 4);
        expectQuiet("single end");
        idleCycle();

        // Capture two cycles into the shift goes to pending
        applyStimulus(4'hF, makeVec(16'h0A00), 1'b1);
        idleCycle();
        applyStimulus(4'hF, makeVec(16'h0B00), 1'b1);
        expectStream("pending valid", 6);
        expectQuiet("pending end");
        checkOutput("pending overflow", 32'(overflow), 32'd0);
        idleCycle();

        // Capture on the last-word cycle loads active directly
        applyStimulus(4'hF, makeVec(16'h1A00), 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("lastword gapfree", 32'(data_out_valid), 32'd1);
            idleCycle();
        end
        checkOutput("lastword gapfree", 32'(data_out_valid), 32'd1);
        applyStimulus(4'hF, makeVec(16'h1B00), 1'b1);
        expectStream("lastword valid", 4);
        expectQuiet("lastword end");
        checkOutput("lastword overflow", 32'(overflow), 32'd0);
        idleCycle();

        // Overflow: third vector dropped
        applyStimulus(4'hF, makeVec(16'h2A00), 1'b1);
        applyStimulus(4'hF, makeVec(16'h2B00), 1'b1);
        checkOutput("overflow before drop", 32'(overflow), 32'd0);
        applyStimulus(4'hF, makeVec(16'h2C00), 1'b0);
        checkOutput("overflow set", 32'(overflow), 32'd1);
        expectStream("overflow valid", 6);
        expectQuiet("overflow end");
        checkOutput("overflow sticky", 32'(overflow), 32'd1);
        idleCycle();

        // Mismatch without bit 0: flag only, no capture
        applyStimulus(4'b0010, makeVec(16'h3A00), 1'b0);
        checkOutput("mismatch set", 32'(valid_mismatch), 32'd1);
        checkOutput("no capture bit0 low", 32'(data_out_valid), 32'd0);
        idleCycle();
        expectQuiet("no capture end");

        // Mismatch with bit 0: captured and emitted
        applyStimulus(4'b0011, makeVec(16'h3B00), 1'b1);
        expectStream("mismatch valid", 4);
        expectQuiet("mismatch end");
        checkOutput("mismatch sticky", 32'(valid_mismatch), 32'd1);
        idleCycle();

        // Reset mid-shift, with a capture offered on the reset edge
        applyStimulus(4'hF, makeVec(16'h4A00), 1'b1);
        applyStimulus(4'hF, makeVec(16'h4B00), 1'b1);
        rst = 1'b1;
        applyStimulus(4'hF, makeVec(16'h4C00), 1'b0);
        sb.delete();
        rst = 1'b0;
        checkOutput("midreset valid", 32'(data_out_valid), 32'd0);
        checkOutput("midreset data", 32'(data_out), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset overflow", 32'(overflow), 32'd0);
        checkOutput("midreset mismatch", 32'(valid_mismatch), 32'd0);
        idleCycle();
        checkOutput("midreset stays idle", 32'(data_out_valid), 32'd0);
        idleCycle();
        applyStimulus(4'hF, makeVec(16'h5A00), 1'b1);
        expectStream("after reset valid", 4);
        expectQuiet("after reset end");

        idleCycle();
        idleCycle();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
